// File: rtl/cpu_reg_file.sv
// Parametrised register file: two registered read ports, one write port, write-to-read bypass,
// optional hardwired zero register and an internal sweep that zeroes every entry.
module cpu_reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              busy,
  input  logic              read,
  input  logic [ADDR_W-1:0] rAddr0,
  input  logic [ADDR_W-1:0] rAddr1,
  output logic [DATA_W-1:0] rData0,
  output logic [DATA_W-1:0] rData1,
  output logic              rValid,
  input  logic              write,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData
);

  typedef enum logic [0:0] {StSweep, StIdle} state_e;

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] idxQ, idxD;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rData0Q, rData0D, rData1Q, rData1D;
  logic              rValidQ, rValidD;

  logic              idle;
  logic              wEff;
  logic              hit0, hit1, zero0, zero1;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;

  always_comb begin
    idle  = (stateQ == StIdle);
    // A write to the hardwired zero register is dropped and must not feed the bypass either.
    wEff  = idle && write && !((ZERO_REG != 0) && (wAddr == '0));
    zero0 = (ZERO_REG != 0) && (rAddr0 == '0);
    zero1 = (ZERO_REG != 0) && (rAddr1 == '0);
    hit0  = wEff && (wAddr == rAddr0);
    hit1  = wEff && (wAddr == rAddr1);

    stateD = stateQ;
    idxD   = idxQ;
    if (!idle) begin
      idxD = idxQ + ADDR_W'(1);
      if (idxQ == ADDR_W'(DEPTH - 1)) stateD = StIdle;
    end else if (clear) begin
      stateD = StSweep;
      idxD   = '0;
    end

    memWe    = rst_n && (!idle || wEff);
    memAddr  = idle ? wAddr : idxQ;
    memWData = idle ? wData : '0;

    rData0D = rData0Q;
    rData1D = rData1Q;
    rValidD = 1'b0;
    if (idle && read) begin
      rValidD = 1'b1;
      rData0D = zero0 ? '0 : (hit0 ? wData : mem[rAddr0]);
      rData1D = zero1 ? '0 : (hit1 ? wData : mem[rAddr1]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= StSweep;
      idxQ    <= '0;
      rData0Q <= '0;
      rData1Q <= '0;
      rValidQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      idxQ    <= idxD;
      rData0Q <= rData0D;
      rData1Q <= rData1D;
      rValidQ <= rValidD;
    end
  end

  // Storage is never reset directly; the sweep after reset zeroes it.
  always_ff @(posedge clk) begin
    if (memWe) mem[memAddr] <= memWData;
  end

  assign busy   = (stateQ == StSweep);
  assign rData0 = rData0Q;
  assign rData1 = rData1Q;
  assign rValid = rValidQ;

endmodule
